// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave memory. Serves classic and registered-feedback bursts
// (constant, linear, wrap-4/8/16) from an internal word array. Out-of-range
// accesses are answered with err.
module wb_mem_responder #(
  parameter int unsigned aw          = 32,
  parameter int unsigned dw          = 32,
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int unsigned IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StSingle, StBurst, StErr} state_e;

  state_e        state_q, state_d;
  state_e        tgt_q, tgt_d;      // state to enter once the wait states expire
  logic [aw-1:0] exp_adr_q, exp_adr_d;
  logic [dw-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [dw-1:0] mem [MEM_WORDS];

  logic          req;
  logic          adr_in_range;
  logic          nxt_in_range;
  logic          hit;
  logic          cti_burst;
  logic          mem_we;
  logic [aw-1:0] nxt_adr;
  logic [IW-1:0] adr_idx;
  logic [IW-1:0] nxt_idx;
  logic [IW-1:0] wr_idx;

  function automatic logic in_range(input logic [aw-1:0] a);
    return a[aw-1:2] < (aw-2)'(MEM_WORDS);
  endfunction

  // Burst address sequencing; wrap modes only touch the low word-index bits.
  function automatic logic [aw-1:0] next_adr(input logic [aw-1:0] a, input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [aw-1:0] n;
    n = a;
    if (cti != 3'b001) begin
      case (bte)
        2'b00:   n = a + aw'(4);
        2'b01:   n[3:2] = a[3:2] + 2'd1;
        2'b10:   n[4:2] = a[4:2] + 3'd1;
        default: n[5:2] = a[5:2] + 4'd1;
      endcase
    end
    return n;
  endfunction

  assign req          = wb_cyc_i & wb_stb_i;
  assign adr_in_range = in_range(wb_adr_i);
  assign adr_idx      = wb_adr_i[IW+1:2];
  assign hit          = req & (wb_adr_i == exp_adr_q);
  assign cti_burst    = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
  assign nxt_adr      = next_adr(exp_adr_q, wb_cti_i, wb_bte_i);
  assign nxt_in_range = in_range(nxt_adr);
  assign nxt_idx      = nxt_adr[IW+1:2];
  // In SINGLE the latched address is the access address; in BURST an ack implies a hit.
  assign wr_idx       = exp_adr_q[IW+1:2];
  assign mem_we       = wb_ack_o & wb_we_i;

  assign wb_dat_o = data_q;
  assign wb_rty_o = 1'b0;

  // Next-state, data prefetch and combinational ack/err.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    exp_adr_d = exp_adr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          exp_adr_d = wb_adr_i;
          cnt_d     = CW'(WAIT_STATES);
          if (!adr_in_range) begin
            tgt_d = StErr;
          end else begin
            data_d = mem[adr_idx];
            tgt_d  = cti_burst ? StBurst : StSingle;
          end
          state_d = (WAIT_STATES != 0) ? StWait : tgt_d;
        end
      end
      StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = tgt_q;
          end
        end
      end
      StSingle: begin
        wb_ack_o = req;
        state_d  = StIdle;
      end
      StBurst: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (wb_stb_i) begin
          if (!hit) begin
            // Address diverged from the predicted sequence: restart with full latency.
            state_d = StIdle;
          end else if (adr_in_range) begin
            wb_ack_o  = 1'b1;
            exp_adr_d = nxt_adr;
            data_d    = nxt_in_range ? mem[nxt_idx] : '0;
            if (wb_cti_i == 3'b111) begin
              state_d = StIdle;
            end
          end else begin
            wb_err_o = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StErr: begin
        wb_err_o = req;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and read-data registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= StIdle;
      tgt_q     <= StSingle;
      exp_adr_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      exp_adr_q <= exp_adr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Byte-lane write port; contents are intentionally not reset.
  always_ff @(posedge wb_clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we && wb_sel_i[k]) begin
        mem[wr_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: one instance without wait states and
// one with two, driven by a shared bus with per-instance cyc gating.
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cur;
  logic        cyc0, cyc1;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  logic        ack_s, err_s;
  logic [31:0] dat_s;

  always #5 clk = ~clk;

  assign cyc0  = cyc & ~cur;
  assign cyc1  = cyc & cur;
  assign ack_s = cur ? ack1 : ack0;
  assign err_s = cur ? err1 : err0;
  assign dat_s = cur ? dat1 : dat0;

  wb_mem_responder #(.aw(32), .dw(32), .MEM_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
  );

  wb_mem_responder #(.aw(32), .dw(32), .MEM_WORDS(256), .WAIT_STATES(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mdl   [2][256];
  int          ws    [2] = '{0, 2};
  logic [31:0] wdata [256];
  logic [3:0]  wsel  [256];
  logic [31:0] rdat  [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference address sequence, expressed as wrap within an aligned block.
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] c,
                                      input logic [1:0] b);
    logic [31:0] span, base;
    if (c == 3'b001) return a;
    if (b == 2'b00) return a + 32'd4;
    span = 32'd8 << b;
    base = a - (a % span);
    return base + ((a - base + 32'd4) % span);
  endfunction

  // Drive one beat and wait (bounded) for ack or err; lat counts clock edges waited.
  task automatic beat(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b,
                      input logic w, input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic ga, output logic ge, output logic [31:0] rd);
    adr = a; cti = c; bte = b; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0; ga = 1'b0; ge = 1'b0; rd = '0;
    while (!ga && !ge && lat < 20) begin
      @(negedge clk);
      ga = ack_s; ge = err_s; rd = dat_s;
      if (!ga && !ge) begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  // Full transfer checked against the model: response kind, latency, read data,
  // and that ack is low on the cycle after the transfer ends.
  task automatic xfer(input int d, input logic [31:0] a0, input int n, input logic w,
                      input logic [2:0] kind, input logic [1:0] b);
    logic [31:0] a, rd;
    logic [2:0]  c;
    logic        ga, ge, inr, done;
    int          lat;
    a = a0; done = 1'b0; cur = d[0];
    for (int i = 0; i < n && !done; i++) begin
      if (kind == 3'b001 || kind == 3'b010) c = (i == n - 1) ? 3'b111 : kind;
      else c = kind;
      inr = (a >> 2) < 32'd256;
      beat(a, c, b, w, wdata[i], wsel[i], lat, ga, ge, rd);
      check("resp", {30'b0, ga, ge}, inr ? 32'd2 : 32'd1);
      if (ga || ge) check("lat", lat, (i == 0) ? 1 + ws[d] : 0);
      if (ga && !w) begin
        rdat[i] = rd;
        check("rdata", rd, mdl[d][a[9:2]]);
      end
      if (ga && w) begin
        for (int k = 0; k < 4; k++)
          if (wsel[i][k]) mdl[d][a[9:2]][8*k +: 8] = wdata[i][8*k +: 8];
      end
      if (!ga) done = 1'b1;
      @(posedge clk); #1;
      a = nxt(a, c, b);
    end
    if (!done) begin
      @(negedge clk);
      check("ack_after", {30'b0, ack_s, err_s}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int          lat, n, d, r, pick;
    logic        ga, ge, w;
    logic [31:0] rd, a;
    logic [2:0]  kind;
    logic [1:0]  b;
    logic [2:0]  ck [6];
    ck = '{3'b000, 3'b111, 3'b011, 3'b100, 3'b101, 3'b110};

    rst = 1'b0; cur = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; cti = '0; bte = '0;
    #12;
    check("rst_ack0", {31'b0, ack0}, 0);
    check("rst_err0", {31'b0, err0}, 0);
    check("rst_rty0", {31'b0, rty0}, 0);
    check("rst_dat0", dat0, 0);
    check("rst_ack2", {31'b0, ack1}, 0);
    check("rst_dat2", dat1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Known contents via one long linear write burst per instance.
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 256; i++) begin
        wdata[i] = $urandom;
        wsel[i]  = 4'hF;
      end
      xfer(dd, 32'h0, 256, 1'b1, 3'b010, 2'b00);
    end

    // Classic write then read.
    wdata[0] = 32'hDEADBEEF; wsel[0] = 4'hF;
    xfer(0, 32'h10, 1, 1'b1, 3'b000, 2'b00);
    xfer(0, 32'h10, 1, 1'b0, 3'b000, 2'b00);
    check("classic_rd", rdat[0], 32'hDEADBEEF);

    // Byte lanes.
    wdata[0] = 32'h11223344; wsel[0] = 4'hF;
    xfer(0, 32'h20, 1, 1'b1, 3'b000, 2'b00);
    wdata[0] = 32'hFFFFFFFF; wsel[0] = 4'b0010;
    xfer(0, 32'h20, 1, 1'b1, 3'b000, 2'b00);
    xfer(0, 32'h20, 1, 1'b0, 3'b000, 2'b00);
    check("lanes_rd", rdat[0], 32'h1122FF44);

    // Linear burst write and read.
    for (int i = 0; i < 4; i++) begin
      wdata[i] = i + 1;
      wsel[i]  = 4'hF;
    end
    xfer(0, 32'h40, 4, 1'b1, 3'b010, 2'b00);
    xfer(0, 32'h40, 4, 1'b0, 3'b010, 2'b00);
    for (int i = 0; i < 4; i++) check("lin_rd", rdat[i], i + 1);

    // Wrap-4 read starting mid-block.
    xfer(0, 32'h48, 4, 1'b0, 3'b010, 2'b01);
    check("wrap_rd0", rdat[0], 32'd3);
    check("wrap_rd1", rdat[1], 32'd4);
    check("wrap_rd2", rdat[2], 32'd1);
    check("wrap_rd3", rdat[3], 32'd2);

    // Wrap-4 with a wrong address on beat 3 (0x44 instead of 0x40).
    cur = 1'b0;
    beat(32'h48, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF, lat, ga, ge, rd);
    check("mm_b1", rd, 32'd3);
    @(posedge clk); #1;
    beat(32'h4C, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF, lat, ga, ge, rd);
    check("mm_b2_lat", lat, 0);
    check("mm_b2", rd, 32'd4);
    @(posedge clk); #1;
    beat(32'h44, 3'b010, 2'b01, 1'b0, 32'h0, 4'hF, lat, ga, ge, rd);
    check("mm_restart_lat", lat, 2);
    check("mm_restart_rd", rd, 32'd2);
    @(posedge clk); #1;
    beat(32'h48, 3'b111, 2'b01, 1'b0, 32'h0, 4'hF, lat, ga, ge, rd);
    check("mm_b4_lat", lat, 0);
    check("mm_b4", rd, 32'd3);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Out of range: classic read/write, then a linear burst over the top.
    xfer(0, 32'h400, 1, 1'b0, 3'b000, 2'b00);
    wdata[0] = 32'hFFFFFFFF; wsel[0] = 4'hF;
    xfer(0, 32'h400, 1, 1'b1, 3'b000, 2'b00);
    xfer(0, 32'h0, 1, 1'b0, 3'b000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'hC0DE0000 + i;
      wsel[i]  = 4'hF;
    end
    xfer(0, 32'h3F8, 4, 1'b1, 3'b010, 2'b00);
    xfer(0, 32'h3F8, 2, 1'b0, 3'b010, 2'b00);
    check("top_rd", rdat[1], 32'hC0DE0001);

    // Wait states: classic access on the WAIT_STATES=2 instance.
    wdata[0] = 32'h0BADF00D; wsel[0] = 4'hF;
    xfer(1, 32'h30, 1, 1'b1, 3'b000, 2'b00);
    xfer(1, 32'h30, 1, 1'b0, 3'b000, 2'b00);
    xfer(1, 32'h400, 1, 1'b0, 3'b000, 2'b00);

    // Reset asserted during beat 2 of a write burst.
    cur = 1'b1;
    beat(32'h80, 3'b010, 2'b00, 1'b1, 32'hA5A50001, 4'hF, lat, ga, ge, rd);
    check("rb_b1", {31'b0, ga}, 1);
    check("rb_b1_lat", lat, 3);
    mdl[1][32] = 32'hA5A50001;
    @(posedge clk); #1;
    adr = 32'h84; wdat = 32'h5A5A0002;
    @(negedge clk);
    check("rb_b2_ack", {31'b0, ack1}, 1);
    #2 rst = 1'b0;
    #1;
    check("rb_ack_drop", {31'b0, ack1}, 0);
    check("rb_dat_clr", dat1, 0);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    xfer(1, 32'h84, 1, 1'b0, 3'b000, 2'b00);
    xfer(1, 32'h80, 1, 1'b0, 3'b000, 2'b00);

    // Randomized traffic on both instances.
    for (int t = 0; t < 80; t++) begin
      d = t % 2;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        kind = ck[$urandom_range(0, 5)];
        n    = 1;
      end else begin
        kind = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b010;
        n    = $urandom_range(1, 8);
      end
      pick = $urandom_range(0, 7);
      if (pick == 0)      a = 32'h3E0 + 4 * $urandom_range(0, 7);
      else if (pick == 1) a = 32'h400 + 4 * $urandom_range(0, 255);
      else                a = 4 * $urandom_range(0, 255);
      w = ($urandom_range(0, 1) == 1);
      b = 2'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        wdata[i] = $urandom;
        wsel[i]  = 4'($urandom_range(0, 15));
      end
      xfer(d, a, n, w, kind, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Synthesizable Wishbone B3 slave memory that serves classic and registered-feedback burst cycles from an internal word array. It is the responder counterpart to the team's Wishbone BFM master, used in core testbenches and as a small on-chip RAM model. Supported bursts are constant-address, linear incrementing, and wrap-4/8/16 incrementing. Out-of-range accesses are answered with an error.

## Interface
- aw, 32, address width (byte address)
- dw, 32, data width; fixed at 32 (4 byte lanes)
- MEM_WORDS, 256, array depth in words; valid word index range is 0..MEM_WORDS-1
- WAIT_STATES, 0, extra cycles before the first ack or err of each access

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-low
- wb_adr_i  in  aw  byte address; word index is adr[aw-1:2]
- wb_dat_i  in  dw  write data
- wb_sel_i  in  4  byte-lane enables
- wb_we_i  in  1  write enable
- wb_cyc_i, wb_stb_i  in  1  cycle and strobe
- wb_cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end of burst
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out  dw  read data, registered
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error (out-of-range access)
- wb_rty_o  out  1  retry; tied to 0

## Operation
- Reset values: state IDLE; wb_dat_o=0; ack, err and rty are 0. Memory contents are not reset.
- Define `req = wb_cyc_i & wb_stb_i`. Address `adr` is in range when its word index is less than MEM_WORDS.
- ack and err are combinational from the registered state, gated by req. The rty output is always 0.

State machine:
- **IDLE:**
  - On req with adr out of range: go to ERR.
  - On req with adr in range: latch exp_adr=adr, load data_r=mem[idx], load cnt=WAIT_STATES.
  - If cnt>0 go to WAIT. Otherwise go to BURST when cti is 001 or 010, else to SINGLE.
  - cti 111 and the reserved values 011-110 are treated as classic when seen in IDLE.
- **WAIT:** decrement cnt. At 0, go to BURST or SINGLE, using cti sampled in IDLE. If cyc drops, go to IDLE.
- **SINGLE:**
  - ack=req.
  - On the edge where ack=1 and we=1, write the enabled byte lanes of mem[idx].
  - Always go to IDLE next, so a classic transfer never acks on two consecutive cycles.
- **BURST:**
  - hit = req & (adr==exp_adr).
  - ack = hit & in range. err = hit & out of range.
  - On an edge with ack=1:
    - commit the write (per sel);
    - set exp_adr=next(exp_adr);
    - prefetch data_r=mem[next(exp_adr)] (out-of-range prefetch returns 0);
    - if cti==111, go to IDLE.
  - On stb=0 (master wait state): hold.
  - On req with adr≠exp_adr: go to IDLE without ack; the access restarts and pays full latency.
  - On cyc=0: go to IDLE. On err: go to IDLE.
- **ERR:** err=req for one cycle, then IDLE. Memory is not modified.

next(a):
- Constant burst (cti 001): a.
- bte 00: a+4, aw-bit wrap-around.
- bte 01: increment a[3:2] modulo 4, upper bits kept.
- bte 10: increment a[4:2] modulo 8.
- bte 11: increment a[5:2] modulo 16.

## Timing
- First ack or err: in cycle N+1+WAIT_STATES, where N is the first cycle req is sampled in IDLE.
- Burst beats: one per cycle while the master keeps stb high and addresses match; ack stays high continuously.
- After the beat with cti=111: ack is low on the next cycle.
- Read data: wb_dat_o is valid exactly in cycles where ack=1. It holds its last value otherwise.
- Write commit: at the rising edge that closes an ack=1 cycle.
- Reset mid-operation: asserting wb_rst_i immediately forces state to IDLE and ack/err low, without waiting for a clock. A write in flight at that edge is not committed.
- Simultaneous cyc drop and ack: the beat is not completed, because ack is gated by req.

## Test plan
- **Classic write/read:** write 0x10 = 0xDEADBEEF (sel F), then read 0x10 with WAIT_STATES=0. Ack comes one cycle after stb, single cycle; read returns 0xDEADBEEF.
- **Byte lanes:** write 0x20 = 0x11223344, then write 0xFFFFFFFF with sel 0010. Read of 0x20 returns 0x1122FF44.
- **Linear burst:** write burst at 0x40, data 1,2,3,4, cti 010×3 then 111. Four consecutive acks. Read burst returns 1,2,3,4 on consecutive cycles; ack low on the cycle after the last beat.
- **Wrap-4 read burst:** starting at 0x48 (bte 01) against the data above, address sequence 0x48, 0x4C, 0x40, 0x44 returns 3,4,1,2. A deliberate address mismatch on beat 3 causes ack low, a restart, and correct data after the restart latency.
- **Out of range:** classic read at MEM_WORDS*4 gives err for one cycle and no ack. A linear burst crossing the top of memory errs on the first out-of-range beat. Memory is unchanged.
- **Wait states and reset:** with WAIT_STATES=2, the first ack comes at N+3. Asserting wb_rst_i during beat 2 of a burst drops ack within the same cycle; a subsequent classic read succeeds normally.
